// File: rtl/user_sha_obi_sbr_pkg.sv
// Shared definitions for the SHA-256 OBI subordinate: bus types, register map, FSM states.
package user_sha_obi_sbr_pkg;

    // OBI subordinate configuration
    localparam int unsigned SbrAddrWidth = 32;
    localparam int unsigned SbrDataWidth = 32;
    localparam int unsigned SbrIdWidth   = 2;

    typedef struct packed {
        int unsigned AddrWidth;
        int unsigned DataWidth;
        int unsigned IdWidth;
    } obi_cfg_t;

    localparam obi_cfg_t SbrObiCfg = '{
        AddrWidth: SbrAddrWidth,
        DataWidth: SbrDataWidth,
        IdWidth:   SbrIdWidth
    };

    typedef struct packed {
        logic [SbrAddrWidth-1:0]   addr;
        logic                      we;
        logic [SbrDataWidth/8-1:0] be;
        logic [SbrDataWidth-1:0]   wdata;
        logic [SbrIdWidth-1:0]     aid;
    } sbr_obi_a_chan_t;

    typedef struct packed {
        sbr_obi_a_chan_t a;
        logic            req;
    } sbr_obi_req_t;

    typedef struct packed {
        logic [SbrDataWidth-1:0] rdata;
        logic [SbrIdWidth-1:0]   rid;
        logic                    err;
    } sbr_obi_r_chan_t;

    typedef struct packed {
        sbr_obi_r_chan_t r;
        logic            gnt;
        logic            rvalid;
    } sbr_obi_rsp_t;

    // Placement in the user address map
    localparam logic [31:0] UserBaseAddr     = 32'h2000_0000;
    localparam logic [31:0] UserShaAddrStart = UserBaseAddr;
    localparam logic [31:0] UserShaAddrRange = 32'h0000_1000;

    // Register map as word offsets (byte address [11:2])
    localparam logic [9:0] MsgLastWord     = 10'h00F;  // MSG0..MSG15 at 0x00..0x3C
    localparam logic [9:0] CtrlWord        = 10'h010;  // 0x40
    localparam logic [9:0] StatusWord      = 10'h011;  // 0x44
    localparam logic [9:0] DigestFirstWord = 10'h012;  // 0x48
    localparam logic [9:0] DigestLastWord  = 10'h019;  // 0x64

    localparam int unsigned NumMsgWords    = 16;
    localparam int unsigned NumDigestWords = 8;

    // Control and status bit positions
    localparam int unsigned CtrlStartBit   = 0;
    localparam int unsigned CtrlInitBit    = 1;
    localparam int unsigned StatusBusyBit  = 0;
    localparam int unsigned StatusDoneBit  = 1;

    typedef enum logic [0:0] {
        StIdle = 1'b0,
        StBusy = 1'b1
    } sha_state_e;

endpackage

// File: rtl/user_sha_obi_sbr.sv
// OBI register front-end for a SHA-256 core: message/digest registers, start/done handshake.
module user_sha_obi_sbr
    import user_sha_obi_sbr_pkg::*;
#(
    parameter obi_cfg_t ObiCfg    = SbrObiCfg,
    parameter type      obi_req_t = sbr_obi_req_t,
    parameter type      obi_rsp_t = sbr_obi_rsp_t
) (
    input  logic         clk_i,
    input  logic         rst_ni,
    input  obi_req_t     obi_req_i,
    output obi_rsp_t     obi_rsp_o,
    output logic         core_start_o,
    output logic         core_init_o,
    output logic [511:0] core_block_o,
    input  logic         core_valid_i,
    input  logic [255:0] core_digest_i
);

    localparam int unsigned IdW = ObiCfg.IdWidth;

    // Register state
    logic [31:0]    r_msg    [NumMsgWords];
    logic [31:0]    r_digest [NumDigestWords];
    sha_state_e     r_state;
    logic           r_done;
    logic           r_start;
    logic           r_init;
    logic           r_rvalid;
    logic [IdW-1:0] r_rid;
    logic           r_err;
    logic [31:0]    r_rdata;

    // Request fields and decode
    logic           w_req;
    logic           w_we;
    logic [3:0]     w_be;
    logic [31:0]    w_wdata;
    logic [IdW-1:0] w_aid;
    logic [9:0]     w_word;
    logic [9:0]     w_dig_off;
    logic [3:0]     w_msg_idx;
    logic [2:0]     w_dig_idx;
    logic           w_is_msg;
    logic           w_is_ctrl;
    logic           w_is_status;
    logic           w_is_digest;
    logic           w_busy;

    // Per-request actions
    logic [31:0]    w_rdata;
    logic           w_err;
    logic           w_msg_we;
    logic           w_start;
    logic           w_done_clr;
    logic           w_capture;
    logic           w_unused;

    assign w_req       = obi_req_i.req;
    assign w_we        = obi_req_i.a.we;
    assign w_be        = obi_req_i.a.be;
    assign w_wdata     = obi_req_i.a.wdata;
    assign w_aid       = obi_req_i.a.aid;
    assign w_word      = obi_req_i.a.addr[11:2];
    assign w_dig_off   = w_word - DigestFirstWord;
    assign w_msg_idx   = w_word[3:0];
    assign w_dig_idx   = w_dig_off[2:0];
    assign w_is_msg    = (w_word <= MsgLastWord);
    assign w_is_ctrl   = (w_word == CtrlWord);
    assign w_is_status = (w_word == StatusWord);
    assign w_is_digest = (w_word >= DigestFirstWord) && (w_word <= DigestLastWord);
    assign w_busy      = (r_state == StBusy);
    assign w_capture   = w_busy && core_valid_i;

    // Address bits above the 4 KiB window and low byte bits are don't-care
    assign w_unused    = ^{obi_req_i, w_dig_off[9:3]};

    // Decode the granted request into read data, error and register side effects
    always_comb begin
        w_rdata    = '0;
        w_err      = 1'b0;
        w_msg_we   = 1'b0;
        w_start    = 1'b0;
        w_done_clr = 1'b0;
        if (w_req) begin
            if (w_is_msg) begin
                if (w_we) begin
                    if (w_busy) w_err = 1'b1;
                    else        w_msg_we = 1'b1;
                end else begin
                    w_rdata = r_msg[w_msg_idx];
                end
            end else if (w_is_ctrl) begin
                // CTRL is write-only; reads return 0 without error
                if (w_we) begin
                    if (w_busy) w_err = 1'b1;
                    else        w_start = w_wdata[CtrlStartBit];
                end
            end else if (w_is_status) begin
                if (w_we) begin
                    w_done_clr = w_wdata[StatusDoneBit];
                end else begin
                    w_rdata[StatusBusyBit] = w_busy;
                    w_rdata[StatusDoneBit] = r_done;
                end
            end else if (w_is_digest) begin
                if (w_we) w_err = 1'b1;
                else      w_rdata = r_digest[w_dig_idx];
            end else begin
                w_err = 1'b1;
            end
        end
    end

    // Response channel: rvalid follows each grant by exactly one cycle
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_rvalid <= 1'b0;
            r_rid    <= '0;
            r_err    <= 1'b0;
            r_rdata  <= '0;
        end else begin
            r_rvalid <= w_req;
            if (w_req) begin
                r_rid   <= w_aid;
                r_err   <= w_err;
                r_rdata <= w_rdata;
            end
        end
    end

    // Drive the OBI response; grant is purely combinational
    always_comb begin
        obi_rsp_o         = '0;
        obi_rsp_o.gnt     = w_req;
        obi_rsp_o.rvalid  = r_rvalid;
        obi_rsp_o.r.rdata = r_rdata;
        obi_rsp_o.r.rid   = r_rid;
        obi_rsp_o.r.err   = r_err;
    end

    // Message registers with byte-enable writes
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            for (int i = 0; i < NumMsgWords; i++) r_msg[i] <= '0;
        end else if (w_msg_we) begin
            for (int b = 0; b < 4; b++) begin
                if (w_be[b]) r_msg[w_msg_idx][8*b +: 8] <= w_wdata[8*b +: 8];
            end
        end
    end

    // Digest capture when the core reports completion of an active hash
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            for (int i = 0; i < NumDigestWords; i++) r_digest[i] <= '0;
        end else if (w_capture) begin
            for (int i = 0; i < NumDigestWords; i++) begin
                r_digest[i] <= core_digest_i[255-32*i -: 32];
            end
        end
    end

    // Hash FSM with registered start pulse, init select and DONE flag
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_state <= StIdle;
            r_start <= 1'b0;
            r_init  <= 1'b1;
            r_done  <= 1'b0;
        end else begin
            r_start <= w_start;
            if (w_start) r_init <= w_wdata[CtrlInitBit];
            case (r_state)
                StIdle: begin
                    if (w_start) begin
                        r_state <= StBusy;
                        r_done  <= 1'b0;
                    end else if (w_done_clr) begin
                        r_done  <= 1'b0;
                    end
                end
                StBusy: begin
                    // Completion wins over a simultaneous DONE clear
                    if (core_valid_i) begin
                        r_state <= StIdle;
                        r_done  <= 1'b1;
                    end else if (w_done_clr) begin
                        r_done  <= 1'b0;
                    end
                end
                default: r_state <= StIdle;
            endcase
        end
    end

    assign core_start_o = r_start;
    assign core_init_o  = r_init;

    // Message block view: MSG0 occupies the most significant word
    always_comb begin
        core_block_o = '0;
        for (int i = 0; i < NumMsgWords; i++) begin
            core_block_o[511-32*i -: 32] = r_msg[i];
        end
    end

endmodule

// File: tb/tb_user_sha_obi_sbr.sv
// Scoreboard bench for user_sha_obi_sbr: directed OBI transactions and core handshakes.
module tb_user_sha_obi_sbr;
    import user_sha_obi_sbr_pkg::*;

    logic         clk_i;
    logic         rst_ni;
    sbr_obi_req_t obi_req;
    sbr_obi_rsp_t obi_rsp;
    logic         core_start;
    logic         core_init;
    logic [511:0] core_block;
    logic         core_valid;
    logic [255:0] core_digest;

    typedef struct {
        logic [31:0]           rdata;
        logic                  err;
        logic [SbrIdWidth-1:0] rid;
        int                    cyc;
    } exp_t;

    exp_t q[$];
    int n_vec   = 0;
    int n_err   = 0;
    int cyc     = 0;
    int n_start = 0;
    logic [SbrIdWidth-1:0] aid_ctr = '0;

    logic [31:0]  msg [16];
    logic [511:0] exp_block;
    logic [255:0] dig_abc;
    logic [255:0] dig_two;

    user_sha_obi_sbr dut (
        .clk_i         (clk_i),
        .rst_ni        (rst_ni),
        .obi_req_i     (obi_req),
        .obi_rsp_o     (obi_rsp),
        .core_start_o  (core_start),
        .core_init_o   (core_init),
        .core_block_o  (core_block),
        .core_valid_i  (core_valid),
        .core_digest_i (core_digest)
    );

    initial clk_i = 1'b0;
    always #5 clk_i = ~clk_i;

    always @(posedge clk_i) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [511:0] act, input logic [511:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Monitor: compare every response against the scoreboard, count start pulses
    always @(negedge clk_i) begin
        exp_t e;
        if (core_start) n_start++;
        if (obi_rsp.rvalid) begin
            if (q.size() == 0) begin
                chk("spurious rvalid", 1'b1, 1'b0);
            end else begin
                e = q.pop_front();
                chk("rdata", obi_rsp.r.rdata, e.rdata);
                chk("err", obi_rsp.r.err, e.err);
                chk("rid", obi_rsp.r.rid, e.rid);
                chk("rvalid latency", cyc, e.cyc + 1);
            end
        end else if (q.size() > 0 && cyc > q[0].cyc + 1) begin
            e = q.pop_front();
            chk("missing rvalid", 1'b0, 1'b1);
        end
    end

    task automatic xact(input logic we, input logic [11:0] addr, input logic [31:0] wdata,
                        input logic [3:0] be, input logic [31:0] exp_rdata, input logic exp_err);
        exp_t e;
        @(posedge clk_i);
        #1;
        obi_req.req     = 1'b1;
        obi_req.a.we    = we;
        obi_req.a.addr  = {20'h0, addr};
        obi_req.a.wdata = wdata;
        obi_req.a.be    = be;
        obi_req.a.aid   = aid_ctr;
        e.rdata = exp_rdata;
        e.err   = exp_err;
        e.rid   = aid_ctr;
        e.cyc   = cyc;
        q.push_back(e);
        aid_ctr = aid_ctr + 1'b1;
        #1;
        chk("gnt", obi_rsp.gnt, 1'b1);
        @(posedge clk_i);
        #1;
        obi_req = '0;
    endtask

    task automatic wr(input logic [11:0] addr, input logic [31:0] d, input logic [3:0] be,
                      input logic exp_err);
        xact(1'b1, addr, d, be, 32'h0, exp_err);
    endtask

    task automatic rd(input logic [11:0] addr, input logic [31:0] exp_rdata,
                      input logic exp_err);
        xact(1'b0, addr, 32'h0, 4'h0, exp_rdata, exp_err);
    endtask

    task automatic idle(input int n);
        repeat (n) @(posedge clk_i);
        #1;
    endtask

    task automatic pulse_valid(input logic [255:0] d);
        @(posedge clk_i);
        #1;
        core_valid  = 1'b1;
        core_digest = d;
        @(posedge clk_i);
        #1;
        core_valid  = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        obi_req     = '0;
        core_valid  = 1'b0;
        core_digest = '0;
        rst_ni      = 1'b0;
        dig_abc = 256'hBA7816BF_8F01CFEA_414140DE_5DAE2223_B00361A3_96177A9C_B410FF61_F20015AD;
        dig_two = 256'h11111111_22222222_33333333_44444444_55555555_66666666_77777777_88888888;
        for (int i = 0; i < 16; i++) msg[i] = 32'h0;
        msg[0]  = 32'h61626380;
        msg[15] = 32'h00000018;

        // Reset state
        #23;
        chk("reset rvalid", obi_rsp.rvalid, 1'b0);
        chk("reset err", obi_rsp.r.err, 1'b0);
        chk("reset rdata", obi_rsp.r.rdata, 32'h0);
        chk("reset rid", obi_rsp.r.rid, 2'b00);
        chk("reset start", core_start, 1'b0);
        chk("reset init", core_init, 1'b1);
        chk("reset block", core_block, 512'h0);
        rst_ni = 1'b1;
        idle(2);

        // Byte-enable write and readback
        wr(12'h00C, 32'hDEADBEEF, 4'b0101, 1'b0);
        rd(12'h00C, 32'h00AD00EF, 1'b0);
        rd(12'h044, 32'h0, 1'b0);

        // Fill message, check block view
        for (int i = 0; i < 16; i++) wr(12'(4 * i), msg[i], 4'hF, 1'b0);
        exp_block = '0;
        for (int i = 0; i < 16; i++) exp_block[511-32*i -: 32] = msg[i];
        chk("block after fill", core_block, exp_block);

        // START with init=1
        wr(12'h040, 32'h3, 4'hF, 1'b0);
        chk("start pulse high", core_start, 1'b1);
        chk("init latched 1", core_init, 1'b1);
        idle(1);
        chk("start pulse low", core_start, 1'b0);
        rd(12'h044, 32'h1, 1'b0);
        chk("start pulse count", n_start, 1);

        // Writes while busy are rejected
        wr(12'h000, 32'hFFFFFFFF, 4'hF, 1'b1);
        wr(12'h040, 32'h1, 4'hF, 1'b1);
        rd(12'h000, 32'h61626380, 1'b0);
        idle(2);
        chk("no second start", n_start, 1);
        chk("block while busy", core_block, exp_block);

        // Completion
        pulse_valid(dig_abc);
        rd(12'h048, 32'hBA7816BF, 1'b0);
        rd(12'h064, 32'hF20015AD, 1'b0);
        rd(12'h044, 32'h2, 1'b0);
        rd(12'h040, 32'h0, 1'b0);

        // Illegal offset and digest write
        rd(12'h080, 32'h0, 1'b1);
        wr(12'h050, 32'h12345678, 4'hF, 1'b1);
        rd(12'h050, 32'h414140DE, 1'b0);

        // START with init=0 clears DONE; DONE clear racing completion keeps DONE set
        wr(12'h040, 32'h1, 4'hF, 1'b0);
        chk("init latched 0", core_init, 1'b0);
        rd(12'h044, 32'h1, 1'b0);
        fork
            wr(12'h044, 32'h2, 4'hF, 1'b0);
            pulse_valid(dig_two);
        join
        rd(12'h044, 32'h2, 1'b0);
        rd(12'h048, 32'h11111111, 1'b0);
        wr(12'h044, 32'h2, 4'hF, 1'b0);
        rd(12'h044, 32'h0, 1'b0);

        // core_valid while idle is ignored
        pulse_valid(dig_abc);
        rd(12'h048, 32'h11111111, 1'b0);
        rd(12'h044, 32'h0, 1'b0);

        // Reset mid-hash, then a stale completion
        wr(12'h040, 32'h1, 4'hF, 1'b0);
        rd(12'h044, 32'h1, 1'b0);
        idle(2);
        #2;
        rst_ni = 1'b0;
        #10;
        rst_ni = 1'b1;
        chk("init after reset", core_init, 1'b1);
        chk("block after reset", core_block, 512'h0);
        pulse_valid(dig_abc);
        rd(12'h044, 32'h0, 1'b0);
        rd(12'h048, 32'h0, 1'b0);
        rd(12'h000, 32'h0, 1'b0);

        idle(3);
        chk("scoreboard drained", q.size(), 0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/user_sha_obi_sbr.md
USER_SHA_OBI_SBR -- requirements
Module: user_sha_obi_sbr

Interface
REQ-001 SHALL have parameter ObiCfg, default croc_pkg::SbrObiCfg, meaning the OBI subordinate configuration.
REQ-002 SHALL have type parameters obi_req_t and obi_rsp_t, defaults croc_pkg::sbr_obi_req_t and croc_pkg::sbr_obi_rsp_t, meaning the OBI request and response structs.
REQ-003 SHALL have port clk_i, input, 1 bit: the single clock.
REQ-004 SHALL have port rst_ni, input, 1 bit: asynchronous active-low reset.
REQ-005 SHALL have port obi_req_i, input, obi_req_t: the OBI request from the user-domain demux.
REQ-006 SHALL have port obi_rsp_o, output, obi_rsp_t: the OBI response.
REQ-007 SHALL have port core_start_o, output, 1 bit: one-cycle start pulse to the hash core.
REQ-008 SHALL have port core_init_o, output, 1 bit: 1 = hash from the initial value, 0 = continue from the previous digest.
REQ-009 SHALL have port core_block_o, output, 512 bits: message block, with MSG0 in bits [511:480].
REQ-010 SHALL have port core_valid_i, input, 1 bit: one-cycle digest-valid pulse from the core.
REQ-011 SHALL have port core_digest_i, input, 256 bits: digest from the core, with H0 in bits [255:224].

Function
REQ-012 SHALL grant combinationally: gnt = req, every cycle.
REQ-013 SHALL assert rvalid exactly one cycle after each grant, with rid equal to the aid of the granted request.
REQ-014 SHALL decode word offset addr[11:2]:
- 0x00-0x3C: MSG0-15, read/write.
- 0x40: CTRL, write-only; reads return 0.
- 0x44: STATUS, read/write.
- 0x48-0x64: DIGEST0-7, read-only.
REQ-015 SHALL return rdata 0 and err=1 for any other offset.
REQ-016 SHALL honour byte enables (be) on MSG writes.
REQ-017 SHALL take read data from register state as it was in the grant cycle, before that cycle's updates.
REQ-018 SHALL implement FSM IDLE/BUSY:
- IDLE->BUSY on an accepted CTRL write with wdata[0]=1 (START).
- BUSY->IDLE on core_valid_i.
REQ-019 SHALL, on START, pulse core_start_o high for exactly one cycle (the cycle after the grant) and latch wdata[1] into core_init_o.
REQ-020 SHALL keep core_block_o equal to the MSG registers at all times.
REQ-021 SHALL, on core_valid_i in BUSY, capture core_digest_i into DIGEST and set STATUS.DONE (bit 1).
REQ-022 SHALL ignore core_valid_i in IDLE.
REQ-023 SHALL report STATUS.BUSY (bit 0) = (state == BUSY).
REQ-024 SHALL clear STATUS.DONE on a STATUS write with wdata[1]=1, and on START.
REQ-025 SHALL, while BUSY, ignore writes to MSG and CTRL and respond with err=1.
REQ-026 SHALL respond with err=1 to writes to DIGEST, with no state change.
REQ-027 SHALL give set priority when a DONE-clear write and core_valid_i occur in the same cycle: DONE ends at 1.

Reset
REQ-028 SHALL, on rst_ni low, asynchronously force: FSM=IDLE, MSG=0, DIGEST=0, DONE=0, core_start_o=0, core_init_o=1, rvalid=0, rid=0, err=0, rdata=0.
REQ-029 SHALL, on reset mid-hash, return to IDLE and ignore any later core_valid_i until a new START.

Structure
REQ-030 SHALL place register offsets, STATUS/CTRL bit indices and the FSM state enum in user_pkg.
REQ-031 SHALL be added to the user address map in user_pkg at croc_pkg::UserBaseAddr, range 32'h0000_1000.
REQ-032 SHALL contain no sub-modules; the hash core is instantiated alongside it, and sha256_core is the natural sibling.

Verification
REQ-033 SHALL cover: write MSG3=0xDEADBEEF with be=4'b0101, then read -> 0x00AD00EF, rvalid one cycle after gnt, err=0.
REQ-034 SHALL cover: fill MSG, write CTRL=0x3 -> core_start_o high exactly one cycle, core_init_o=1, STATUS=0x1.
REQ-035 SHALL cover: core_valid_i with digest 0xBA7816BF... -> DIGEST0 reads 0xBA7816BF and STATUS=0x2.
REQ-036 SHALL cover: while BUSY, write MSG0 and CTRL=0x1 -> err=1, MSG0 unchanged, no second start pulse.
REQ-037 SHALL cover: read offset 0x80 and write DIGEST2 -> err=1, rdata=0.
REQ-038 SHALL cover: assert rst_ni low while BUSY, then a core_valid_i pulse -> STATUS=0, DIGEST still 0.
